// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter that time-shares one ALU between two requesters.
// Operands/control are registered toward the ALU; result and zero flag are registered back.
module alu_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [WIDTH-1:0]  req_A_0,
  input  logic [WIDTH-1:0]  req_A_1,
  input  logic [WIDTH-1:0]  req_B_0,
  input  logic [WIDTH-1:0]  req_B_1,
  input  logic [CTRL_W-1:0] req_ctrl_0,
  input  logic [CTRL_W-1:0] req_ctrl_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [WIDTH-1:0]  resp_result,
  output logic              resp_zero,
  output logic [WIDTH-1:0]  alu_A,
  output logic [WIDTH-1:0]  alu_B,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   owner;
  logic   sel;
  logic   any_valid;
  logic   resp_take;

  // Pointer only matters under contention; a lone requester always wins.
  assign any_valid = req_valid_0 | req_valid_1;
  assign sel       = (req_valid_0 && req_valid_1) ? ptr : req_valid_1;
  assign resp_take = owner ? resp_ready_1 : resp_ready_0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    busy         = (state != IDLE);
    if (state == IDLE && any_valid) begin
      req_ready_0 = !sel;
      req_ready_1 = sel;
    end
    if (state == RESP) begin
      resp_valid_0 = !owner;
      resp_valid_1 = owner;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr         <= 1'b0;
      owner       <= 1'b0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_ctrl    <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        owner    <= sel;
        ptr      <= !sel;
        alu_A    <= sel ? req_A_1    : req_A_0;
        alu_B    <= sel ? req_B_1    : req_B_0;
        alu_ctrl <= sel ? req_ctrl_1 : req_ctrl_0;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_A_0 = '0, req_A_1 = '0, req_B_0 = '0, req_B_1 = '0;
  logic [4:0]  req_ctrl_0 = '0, req_ctrl_1 = '0;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0 = 1'b1, resp_ready_1 = 1'b1;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [31:0] alu_A, alu_B;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(32), .CTRL_W(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_A_0(req_A_0), .req_A_1(req_A_1),
    .req_B_0(req_B_0), .req_B_1(req_B_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // ALU stand-in: 00000 ADD, 10000 SUB, 01000 SLT, 01100 SLTU, anything else -> 0
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      5'b00000: alu_result = alu_A + alu_B;
      5'b10000: alu_result = alu_A - alu_B;
      5'b01000: alu_result = {31'd0, $signed(alu_A) < $signed(alu_B)};
      5'b01100: alu_result = {31'd0, alu_A < alu_B};
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
    req_valid_0 = 1'b1; req_A_0 = a; req_B_0 = b; req_ctrl_0 = c;
  endtask

  task automatic req1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
    req_valid_1 = 1'b1; req_A_1 = a; req_B_1 = b; req_ctrl_1 = c;
  endtask

  // Single port-0 operation with resp_ready_0 high: accept, EXEC, RESP, back to IDLE.
  task automatic op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] c, input logic [31:0] res, input logic z);
    req0(a, b, c);
    #1 check({tag, "_ready0"}, {31'd0, req_ready_0}, 32'd1);
    step();
    req_valid_0 = 1'b0;
    check({tag, "_exec_valid"}, {31'd0, resp_valid_0}, 32'd0);
    step();
    check({tag, "_valid0"}, {31'd0, resp_valid_0}, 32'd1);
    check({tag, "_result"}, resp_result, res);
    check({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, z});
    step();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12 RESET_N = 1'b1;
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_zero", {31'd0, resp_zero}, 32'd0);
    check("rst_aluA", alu_A, 32'd0);
    check("rst_ctrl", {27'd0, alu_ctrl}, 32'd0);
    check("rst_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    check("rst_ready_idle", {30'd0, req_ready_1, req_ready_0}, 32'd0);

    // Single request, port 0: 5+3
    req0(32'd5, 32'd3, 5'b00000);
    #1 check("add_ready", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    step();
    req_valid_0 = 1'b0;
    check("add_aluA", alu_A, 32'd5);
    check("add_aluB", alu_B, 32'd3);
    check("add_exec_busy", {31'd0, busy}, 32'd1);
    check("add_exec_rv", {31'd0, resp_valid_0}, 32'd0);
    step();
    check("add_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd1);
    check("add_result", resp_result, 32'd8);
    check("add_zero", {31'd0, resp_zero}, 32'd0);
    step();
    check("add_done", {31'd0, busy}, 32'd0);

    // Fresh reset so the pointer is back at port 0, then contention
    RESET_N = 1'b0;
    #3 RESET_N = 1'b1;
    step();
    req0(32'd7, 32'd7, 5'b10000);
    req1(32'd1, 32'd2, 5'b00000);
    #1 check("both_ready", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    step();
    req_valid_0 = 1'b0;
    check("both_exec_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    step();
    check("sub_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd1);
    check("sub_result", resp_result, 32'd0);
    check("sub_zero", {31'd0, resp_zero}, 32'd1);
    req0(32'd10, 32'd4, 5'b00000);
    step();
    check("alt_ready", {30'd0, req_ready_1, req_ready_0}, 32'd2);
    resp_ready_1 = 1'b0;
    step();
    req_valid_1 = 1'b0;
    step();
    check("p1_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd2);
    check("p1_result", resp_result, 32'd3);

    // Backpressure on port 1; port 0 keeps asking, non-owner resp_ready toggles
    for (int i = 0; i < 5; i++) begin
      resp_ready_0 = i[0];
      step();
      check("bp_result", resp_result, 32'd3);
      check("bp_ready0", {31'd0, req_ready_0}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_rv1", {31'd0, resp_valid_1}, 32'd1);
    end
    resp_ready_0 = 1'b1;
    resp_ready_1 = 1'b1;
    step();
    check("bp_grant0", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    step();
    req_valid_0 = 1'b0;
    step();
    check("bp_p0_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd1);
    check("bp_p0_result", resp_result, 32'd14);
    step();

    // Unsupported code, unsigned and signed compares
    op0("unsup", 32'd9, 32'd4, 5'b00001, 32'd0, 1'b1);
    op0("sltu", 32'hFFFF_FFFF, 32'd1, 5'b01100, 32'd0, 1'b1);
    op0("slt", 32'hFFFF_FFFF, 32'd1, 5'b01000, 32'd1, 1'b0);

    // Reset during EXEC discards the operation
    req1(32'd9, 32'd9, 5'b00000);
    #1 check("mid_ready1", {31'd0, req_ready_1}, 32'd1);
    step();
    req_valid_1 = 1'b0;
    check("mid_exec_busy", {31'd0, busy}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_aluA", alu_A, 32'd0);
    check("mid_result", resp_result, 32'd0);
    check("mid_zero", {31'd0, resp_zero}, 32'd0);
    #4 RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_rv", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    end
    req0(32'd1, 32'd1, 5'b00000);
    req1(32'd2, 32'd2, 5'b00000);
    #1 check("mid_ptr0", {30'd0, req_ready_1, req_ready_0}, 32'd1);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two independent requesters (port 0, port 1) using a valid/ready handshake and round-robin priority. Operands and the 5-bit ALU control code are registered before they reach the ALU, and the result and zero flag are registered before they return. The block sits between the ALU instance and its clients, for example the execute stage and an address/branch helper. It owns every ALU input; the clients never drive the ALU directly.

## Interface
- WIDTH, 32: operand/result width (must match ALU)
- CTRL_W, 5: ALU control code width
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  requester has an operation pending
- req_ready_0 / req_ready_1  out  1  operation accepted this cycle
- req_A_0 / req_A_1  in  WIDTH  operand A
- req_B_0 / req_B_1  in  WIDTH  operand B
- req_ctrl_0 / req_ctrl_1  in  CTRL_W  ALU control code, passed through unmodified
- resp_valid_0 / resp_valid_1  out  1  result available for that port
- resp_ready_0 / resp_ready_1  in  1  port consumes result
- resp_result  out  WIDTH  registered ALU result, shared by both ports
- resp_zero  out  1  registered ALU zero flag
- alu_A, alu_B  out  WIDTH  to ALU inputs (registered)
- alu_ctrl  out  CTRL_W  to ALU control (registered)
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Winner is the valid port with priority; if only one port is valid, that port wins.
  - req_ready_winner = 1, combinational from req_valid, IDLE state and priority pointer. Only one ready is ever high.
  - On the edge where valid&&ready: capture A, B, ctrl into alu_A/alu_B/alu_ctrl, record owner, go to EXEC.
- EXEC (exactly 1 cycle): ALU evaluates the registered operands. At the edge, capture alu_result→resp_result and alu_zero→resp_zero, then go to RESP.
- RESP:
  - resp_valid_owner = 1; the other port's resp_valid stays 0.
  - Hold result and flag stable until resp_ready_owner = 1 at an edge, then go to IDLE.
  - resp_ready from the non-owner is ignored.
- Priority pointer: 1 bit, reset value = port 0. After each grant it points to the non-granted port, which gives strict alternation under continuous contention.
- No requests are accepted outside IDLE. Both req_ready outputs are 0 in EXEC and RESP.
- Requester rule: the request must stay stable while valid and not ready. A request withdrawn before its grant is simply not serviced.
- Control codes are not decoded. Codes the ALU treats as unsupported return result 0 and zero = 1.
- Arithmetic and width: values pass through bit-exact. The arbiter performs no arithmetic.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, pointer = 0.
  - alu_A = alu_B = 0, alu_ctrl = 0.
  - resp_result = 0, resp_zero = 0, all resp_valid = 0, busy = 0.
  - req_ready may go high in the first cycle after reset release if req_valid is high.
- Latency: accept at edge T. EXEC occupies T..T+1. resp_valid is high from after edge T+1 (the cycle after EXEC).
- Minimum occupancy is 3 cycles per operation with resp_ready tied high: IDLE, EXEC, RESP.
- Back-to-back: after the RESP handshake the FSM returns to IDLE. The next grant occurs in the IDLE cycle; no bypass is allowed.
- Reset asserted in EXEC or RESP: the operation is discarded, no resp_valid is issued, and the pointer returns to port 0.

## Test plan
- Single request, port 0: A=5, B=3, ctrl=00000 → ready_0 in the same cycle; resp_valid_0 two cycles after acceptance, resp_result=8, resp_zero=0.
- Simultaneous requests after reset: port 0 SUB 7-7, port 1 ADD 1+2 → port 0 served first with result 0 and zero=1; port 1 served next with result 3. Neither port is granted twice in a row.
- Backpressure: hold resp_ready_1=0 for 5 cycles while port 0 keeps valid high → resp_result stays stable, req_ready_0 stays 0, busy=1; the port-0 grant comes only after the resp_ready_1 handshake.
- Signed compare through the arbiter: A=0xFFFFFFFF, B=1, ctrl=01000 → result 1; ctrl=01100 → result 0.
- Unsupported ctrl=00001 → result 0, resp_zero=1, and the FSM completes normally.
- Reset mid-operation: assert RESET_N=0 during EXEC → all outputs return to their reset values immediately; no resp_valid appears after release.
